lcd_frame_sequencer: RTL and testbench

Pixel-source controller for the `st7735` driver. It watches the pixel coordinates the driver requests and detects frame boundaries. It returns an RGB565 color for every pixel and steps through a fixed set of test patterns, either automatically every N frames or on a user step request. Pattern changes only take effect at a frame boundary, so no frame ever shows two patterns. It sits between board-level controls (buttons, straps) and the driver's `x`/`y`/`color` port, replacing the constant-color logic at top level.

---
 rtl/lcd_seq_pkg.sv | 28 ++
 rtl/lcd_pattern_gen.sv | 30 +++
 rtl/lcd_frame_sequencer.sv | 128 ++++++++++++
 tb/tb_lcd_frame_sequencer.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_seq_pkg.sv
// Shared constants for the LCD frame sequencer: pattern indices, RGB565 colors
// and the two-state run/idle encoding.
package lcd_seq_pkg;

   localparam logic [2:0] PAT_WHITE    = 3'd0;
   localparam logic [2:0] PAT_RED      = 3'd1;
   localparam logic [2:0] PAT_GREEN    = 3'd2;
   localparam logic [2:0] PAT_BLUE     = 3'd3;
   localparam logic [2:0] PAT_CHECKER  = 3'd4;
   localparam logic [2:0] PAT_GRADIENT = 3'd5;

   localparam int NUM_PATTERNS = 6;

   localparam logic [15:0] C_BLACK      = 16'h0000;
   localparam logic [15:0] C_WHITE      = 16'hFFFF;
   localparam logic [15:0] C_RED        = 16'hF800;
   localparam logic [15:0] C_GREEN      = 16'h07E0;
   localparam logic [15:0] C_BLUE       = 16'h001F;
   localparam logic [15:0] C_CHECK_DARK = 16'h5555;

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_RUN  = 1'b1;

   function automatic logic [2:0] next_pattern(input logic [2:0] p);
      return (p == 3'(NUM_PATTERNS - 1)) ? PAT_WHITE : p + 3'd1;
   endfunction

endpackage

// File: rtl/lcd_pattern_gen.sv
// Purely combinational test-pattern generator: (pattern, ofs, x, y) -> RGB565.
// Only y[6:1] can influence any pattern, so the row LSB is not brought in.
module lcd_pattern_gen
   import lcd_seq_pkg::*;
(
   input  logic [2:0]  pattern,
   input  logic [3:0]  ofs,
   input  logic [7:0]  x,
   input  logic [6:1]  y_hi,
   output logic [15:0] color
);

   logic chk_dark;

   always_comb begin
      // Bit 3 of (x + ofs) depends only on the low nibbles, so a 4-bit sum suffices.
      chk_dark = ((x[3:0] + ofs) >= 4'd8) ^ y_hi[3];
      color    = C_BLACK;
      case (pattern)
         PAT_WHITE:    color = C_WHITE;
         PAT_RED:      color = C_RED;
         PAT_GREEN:    color = C_GREEN;
         PAT_BLUE:     color = C_BLUE;
         PAT_CHECKER:  color = chk_dark ? C_CHECK_DARK : C_WHITE;
         PAT_GRADIENT: color = {x[7:3], y_hi[6:1], 5'b0};
         default:      color = C_BLACK;
      endcase
   end

endmodule

// File: rtl/lcd_frame_sequencer.sv
// Pixel-source controller: detects frame starts from the driver's (x,y) stream and
// steps through test patterns, switching only at frame boundaries.
module lcd_frame_sequencer
   import lcd_seq_pkg::*;
#(
   parameter int X_MAX              = 159,
   parameter int Y_MAX              = 127,
   parameter int FRAMES_PER_PATTERN = 60
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [7:0]  x,
   input  logic [6:0]  y,
   input  logic        step,
   input  logic        hold,
   output logic [15:0] color,
   output logic [2:0]  pattern,
   output logic        frame_start,
   output logic [15:0] frame_count
);

   localparam int FCNT_W = (FRAMES_PER_PATTERN > 1) ? $clog2(FRAMES_PER_PATTERN) : 1;
   localparam logic [FCNT_W-1:0] FCNT_LAST = FCNT_W'(FRAMES_PER_PATTERN - 1);

   generate
      if (X_MAX < 0 || X_MAX > 255 || Y_MAX < 0 || Y_MAX > 127 || FRAMES_PER_PATTERN < 1) begin : g_bad_params
         $error("lcd_frame_sequencer: parameter out of range");
      end
   endgenerate

   logic [0:0]        state_q, state_d;
   logic [7:0]        px_q, px_d;
   logic [6:0]        py_q, py_d;
   logic [2:0]        pattern_q, pattern_d;
   logic [FCNT_W-1:0] fcnt_q, fcnt_d;
   logic [3:0]        ofs_q, ofs_d;
   logic              step_pend_q, step_pend_d;
   logic              frame_start_q, frame_start_d;
   logic [15:0]       frame_count_q, frame_count_d;

   logic              boundary;
   logic              advance;
   logic [2:0]        pat_eff;
   logic [3:0]        ofs_eff;
   logic [15:0]       gen_color;

   // A boundary is the first cycle at (0,0); a driver lingering there counts once.
   assign boundary = (x == 8'd0) && (y == 7'd0) && !((px_q == 8'd0) && (py_q == 7'd0));

   always_comb begin
      state_d       = state_q;
      px_d          = x;
      py_d          = y;
      pattern_d     = pattern_q;
      fcnt_d        = fcnt_q;
      ofs_d         = ofs_q;
      step_pend_d   = step_pend_q | step;
      frame_start_d = boundary;
      frame_count_d = frame_count_q;
      advance       = 1'b0;
      if (boundary) begin
         frame_count_d = frame_count_q + 16'd1;
         if (state_q == ST_IDLE) begin
            state_d   = ST_RUN;
            pattern_d = PAT_WHITE;
            fcnt_d    = '0;
            ofs_d     = '0;
         end else begin
            advance = step_pend_q | step | (~hold & (fcnt_q == FCNT_LAST));
            if (advance) begin
               pattern_d   = next_pattern(pattern_q);
               fcnt_d      = '0;
               ofs_d       = '0;
               step_pend_d = 1'b0;
            end else begin
               if (!hold) begin
                  fcnt_d = fcnt_q + FCNT_W'(1);
               end
               if (pattern_q == PAT_CHECKER) begin
                  ofs_d = ofs_q + 4'd1;
               end
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= ST_IDLE;
         px_q          <= '1;
         py_q          <= '1;
         pattern_q     <= PAT_WHITE;
         fcnt_q        <= '0;
         ofs_q         <= '0;
         step_pend_q   <= 1'b0;
         frame_start_q <= 1'b0;
         frame_count_q <= '0;
      end else begin
         state_q       <= state_d;
         px_q          <= px_d;
         py_q          <= py_d;
         pattern_q     <= pattern_d;
         fcnt_q        <= fcnt_d;
         ofs_q         <= ofs_d;
         step_pend_q   <= step_pend_d;
         frame_start_q <= frame_start_d;
         frame_count_q <= frame_count_d;
      end
   end

   // Pixel (0,0) of a new frame must already show that frame's pattern and offset.
   assign pat_eff = boundary ? pattern_d : pattern_q;
   assign ofs_eff = boundary ? ofs_d : ofs_q;

   lcd_pattern_gen u_pattern_gen (
      .pattern (pat_eff),
      .ofs     (ofs_eff),
      .x       (x),
      .y_hi    (y[6:1]),
      .color   (gen_color)
   );

   assign color       = ((state_q == ST_RUN) || boundary) ? gen_color : C_BLACK;
   assign pattern     = pattern_q;
   assign frame_start = frame_start_q;
   assign frame_count = frame_count_q;

endmodule

// File: tb/tb_lcd_frame_sequencer.sv
// Self-checking bench for lcd_frame_sequencer: a reference model pushes expected
// per-pixel outputs to a queue; each scenario pops and compares them.
module tb_lcd_frame_sequencer;

   localparam int XM  = 31;
   localparam int YM  = 15;
   localparam int FPP = 2;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [7:0]  x = '0;
   logic [6:0]  y = '0;
   logic        step = 1'b0;
   logic        hold = 1'b0;
   logic [15:0] color;
   logic [2:0]  pattern;
   logic        frame_start;
   logic [15:0] frame_count;

   always #5 clk = ~clk;

   lcd_frame_sequencer #(
      .X_MAX              (XM),
      .Y_MAX              (YM),
      .FRAMES_PER_PATTERN (FPP)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .x           (x),
      .y           (y),
      .step        (step),
      .hold        (hold),
      .color       (color),
      .pattern     (pattern),
      .frame_start (frame_start),
      .frame_count (frame_count)
   );

   typedef struct {
      logic [15:0] color;
      logic [2:0]  pat;
      logic        fs;
      logic [15:0] fc;
   } exp_t;

   exp_t sb_q[$];
   int checks = 0;
   int failures = 0;

   // reference model state
   bit          m_run;
   int          m_pat, m_fcnt, m_ofs;
   bit          m_pend, m_fs;
   logic [15:0] m_fc;
   int          m_px, m_py;

   function automatic logic [15:0] ref_color(input int p, input int o, input int xx, input int yy);
      case (p)
         0: return 16'hFFFF;
         1: return 16'hF800;
         2: return 16'h07E0;
         3: return 16'h001F;
         4: return ((((xx + o) >> 3) & 1) ^ ((yy >> 3) & 1)) != 0 ? 16'h5555 : 16'hFFFF;
         5: return 16'(((xx >> 3) << 11) | ((yy >> 1) << 5));
         default: return 16'h0000;
      endcase
   endfunction

   task automatic model_reset();
      m_run = 0; m_pat = 0; m_fcnt = 0; m_ofs = 0; m_pend = 0; m_fs = 0;
      m_fc = '0; m_px = 255; m_py = 127;
   endtask

   // Drive one pixel cycle, push the model's expectation, stop at the negedge.
   task automatic pix(input int xx, input int yy, input bit st, input bit hd, input bit rs);
      exp_t e;
      bit bnd, adv;
      int np, no, nf;
      bit npend;
      @(posedge clk);
      #1;
      x = 8'(xx); y = 7'(yy); step = st; hold = hd; reset = rs;
      bnd = (xx == 0 && yy == 0) && !(m_px == 0 && m_py == 0);
      np = m_pat; no = m_ofs; nf = m_fcnt; npend = m_pend | st;
      if (bnd && !m_run) begin
         np = 0; no = 0; nf = 0;
      end else if (bnd) begin
         adv = m_pend || st || (!hd && m_fcnt == FPP - 1);
         if (adv) begin
            np = (m_pat + 1) % 6; nf = 0; no = 0; npend = 0;
         end else begin
            if (!hd) nf = m_fcnt + 1;
            if (m_pat == 4) no = (m_ofs + 1) % 16;
         end
      end
      e.color = (m_run || bnd) ? ref_color(bnd ? np : m_pat, bnd ? no : m_ofs, xx, yy) : 16'h0000;
      e.pat = 3'(m_pat);
      e.fs = m_fs;
      e.fc = m_fc;
      sb_q.push_back(e);
      if (rs) begin
         model_reset();
      end else begin
         if (bnd) begin
            m_fc = m_fc + 16'd1;
            m_run = 1;
         end
         m_pat = np; m_ofs = no; m_fcnt = nf; m_pend = npend;
         m_fs = bnd; m_px = xx; m_py = yy;
      end
      @(negedge clk);
   endtask

   // One full frame; returns observed (0,0)/(7,0) colors, pattern after the boundary
   // and the number of frame_start pulses seen.
   task automatic drive_frame(input bit hd, input int s0, input int s1, input int s2,
                              output logic [15:0] c00, output logic [15:0] c70,
                              output int pat1, output int fs_cnt);
      exp_t e;
      int idx;
      fs_cnt = 0; c00 = 'x; c70 = 'x; pat1 = -1;
      for (int yy = 0; yy <= YM; yy++) begin
         for (int xx = 0; xx <= XM; xx++) begin
            idx = yy * (XM + 1) + xx;
            pix(xx, yy, (idx == s0) || (idx == s1) || (idx == s2), hd, 1'b0);
            e = sb_q.pop_front();
            checks++;
            if ({color, pattern, frame_start, frame_count} !== {e.color, e.pat, e.fs, e.fc}) begin
               failures++;
               $display("FAIL pixel x=%0d y=%0d got color=%h pat=%0d fs=%0b fc=%0d want color=%h pat=%0d fs=%0b fc=%0d",
                        xx, yy, color, pattern, frame_start, frame_count, e.color, e.pat, e.fs, e.fc);
            end
            if (idx == 0) c00 = color;
            if (xx == 7 && yy == 0) c70 = color;
            if (idx == 1) pat1 = int'(pattern);
            if (frame_start) fs_cnt++;
         end
      end
   endtask

   task automatic test_reset();
      exp_t e;
      model_reset();
      for (int i = 0; i < 3; i++) begin
         pix(5, 3, 1'b0, 1'b0, 1'b1);
         e = sb_q.pop_front();
      end
      pix(5, 3, 1'b0, 1'b0, 1'b0);
      e = sb_q.pop_front();
      checks++;
      if ({color, pattern, frame_start, frame_count} !== {16'h0000, 3'd0, 1'b0, 16'd0}) begin
         failures++;
         $display("FAIL reset_state got color=%h pat=%0d fs=%0b fc=%0d want 0000/0/0/0", color, pattern, frame_start, frame_count);
      end
      for (int i = 6; i < 12; i++) begin
         pix(i, 3, 1'b0, 1'b0, 1'b0);
         e = sb_q.pop_front();
         checks++;
         if (color !== e.color) begin
            failures++;
            $display("FAIL idle_black x=%0d got color=%h want %h", i, color, e.color);
         end
      end
      $display("test_reset done: idle outputs checked");
   endtask

   task automatic test_sweep();
      int exp_seq[13] = '{0, 0, 1, 1, 2, 2, 3, 3, 4, 4, 5, 5, 0};
      logic [15:0] c00, c70;
      int pat1, fs_cnt;
      for (int f = 1; f <= 13; f++) begin
         drive_frame(1'b0, -1, -1, -1, c00, c70, pat1, fs_cnt);
         checks++;
         if (pat1 !== exp_seq[f-1] || fs_cnt !== 1) begin
            failures++;
            $display("FAIL sweep_frame%0d got pattern=%0d fs_pulses=%0d want pattern=%0d fs_pulses=1", f, pat1, fs_cnt, exp_seq[f-1]);
         end
         if (f == 3) begin
            checks++;
            if (c00 !== 16'hF800) begin
               failures++;
               $display("FAIL sweep_frame3_pixel00 got %h want F800", c00);
            end
         end
         $display("sweep frame %0d: pattern=%0d pixel00=%h", f, pat1, c00);
      end
      checks++;
      if (frame_count !== 16'd13) begin
         failures++;
         $display("FAIL sweep_frame_count got %0d want 13", frame_count);
      end
   endtask

   task automatic test_step();
      int exp_pat[5] = '{0, 1, 2, 2, 3};
      logic [15:0] c00, c70;
      int pat1, fs_cnt;
      drive_frame(1'b0, -1, -1, -1, c00, c70, pat1, fs_cnt);   // frame 14
      for (int k = 0; k < 4; k++) begin
         if (k == 0) begin
            drive_frame(1'b0, 10, 40, 90, c00, c70, pat1, fs_cnt);   // frame 15: three steps
         end else if (k == 3) begin
            drive_frame(1'b1, 0, -1, -1, c00, c70, pat1, fs_cnt);    // step on the boundary
         end else begin
            drive_frame(1'b0, -1, -1, -1, c00, c70, pat1, fs_cnt);
         end
         checks++;
         if (pat1 !== exp_pat[k + 1]) begin
            failures++;
            $display("FAIL step_frame%0d got pattern=%0d want %0d", 15 + k, pat1, exp_pat[k + 1]);
         end
         $display("step frame %0d: pattern=%0d", 15 + k, pat1);
      end
   endtask

   task automatic test_hold();
      logic [15:0] c00, c70;
      int pat1, fs_cnt;
      for (int f = 0; f < 10; f++) begin
         drive_frame(1'b1, -1, -1, -1, c00, c70, pat1, fs_cnt);
         checks++;
         if (pat1 !== 3 || dut.fcnt_q !== '0) begin
            failures++;
            $display("FAIL hold_frame%0d got pattern=%0d fcnt=%0d want pattern=3 fcnt=0", f, pat1, dut.fcnt_q);
         end
      end
      drive_frame(1'b1, 50, -1, -1, c00, c70, pat1, fs_cnt);
      checks++;
      if (pat1 !== 3) begin
         failures++;
         $display("FAIL hold_step_frame got pattern=%0d want 3", pat1);
      end
      $display("hold: 11 frames held on pattern 3, step issued");
   endtask

   task automatic test_checker();
      logic [15:0] exp70[3] = '{16'hFFFF, 16'h5555, 16'h5555};
      int exp_wrap[4] = '{4, 5, 5, 0};
      logic [15:0] c00, c70;
      int pat1, fs_cnt;
      for (int f = 0; f < 3; f++) begin
         drive_frame(1'b1, -1, -1, -1, c00, c70, pat1, fs_cnt);
         checks++;
         if (pat1 !== 4 || c00 !== 16'hFFFF || c70 !== exp70[f]) begin
            failures++;
            $display("FAIL checker_ofs%0d got pattern=%0d p00=%h p70=%h want 4/FFFF/%h", f, pat1, c00, c70, exp70[f]);
         end
         $display("checker frame ofs=%0d: p00=%h p70=%h", f, c00, c70);
      end
      for (int f = 0; f < 4; f++) begin
         drive_frame(1'b0, -1, -1, -1, c00, c70, pat1, fs_cnt);
         checks++;
         if (pat1 !== exp_wrap[f]) begin
            failures++;
            $display("FAIL wrap_frame%0d got pattern=%0d want %0d", f, pat1, exp_wrap[f]);
         end
      end
      checks++;
      if (c00 !== 16'hFFFF || c70 !== 16'hFFFF) begin
         failures++;
         $display("FAIL wrap_white got p00=%h p70=%h want FFFF/FFFF", c00, c70);
      end
   endtask

   task automatic test_hold00();
      exp_t e;
      int fs_cnt = 0;
      for (int i = 0; i < 20; i++) begin
         if (i < 16) pix(0, 0, 1'b0, 1'b0, 1'b0);
         else pix(i - 15, 0, 1'b0, 1'b0, 1'b0);
         e = sb_q.pop_front();
         checks++;
         if ({color, pattern, frame_start, frame_count} !== {e.color, e.pat, e.fs, e.fc}) begin
            failures++;
            $display("FAIL hold00_cycle%0d got color=%h pat=%0d fs=%0b fc=%0d want color=%h pat=%0d fs=%0b fc=%0d",
                     i, color, pattern, frame_start, frame_count, e.color, e.pat, e.fs, e.fc);
         end
         if (frame_start) fs_cnt++;
      end
      checks++;
      if (fs_cnt !== 1 || frame_count !== 16'd37) begin
         failures++;
         $display("FAIL hold00_single got fs_pulses=%0d fc=%0d want 1/37", fs_cnt, frame_count);
      end
      $display("hold00: fs_pulses=%0d frame_count=%0d", fs_cnt, frame_count);
   endtask

   task automatic test_reset_mid();
      exp_t e;
      logic [15:0] c00, c70;
      int pat1, fs_cnt;
      pix(79, 64, 1'b0, 1'b0, 1'b0);
      e = sb_q.pop_front();
      pix(80, 64, 1'b0, 1'b0, 1'b1);
      e = sb_q.pop_front();
      pix(81, 64, 1'b0, 1'b0, 1'b0);
      e = sb_q.pop_front();
      checks++;
      if ({color, pattern, frame_start, frame_count} !== {16'h0000, 3'd0, 1'b0, 16'd0}) begin
         failures++;
         $display("FAIL reset_mid got color=%h pat=%0d fs=%0b fc=%0d want 0000/0/0/0", color, pattern, frame_start, frame_count);
      end
      for (int i = 82; i < 100; i++) begin
         pix(i, 64, 1'b0, 1'b0, 1'b0);
         e = sb_q.pop_front();
         checks++;
         if (color !== 16'h0000) begin
            failures++;
            $display("FAIL reset_mid_black x=%0d got %h want 0000", i, color);
         end
      end
      drive_frame(1'b0, -1, -1, -1, c00, c70, pat1, fs_cnt);
      checks++;
      if (pat1 !== 0 || c00 !== 16'hFFFF || fs_cnt !== 1 || frame_count !== 16'd1) begin
         failures++;
         $display("FAIL reset_mid_rerun got pattern=%0d p00=%h fs_pulses=%0d fc=%0d want 0/FFFF/1/1", pat1, c00, fs_cnt, frame_count);
      end
      $display("reset_mid: re-entered run, pattern=%0d fc=%0d", pat1, frame_count);
   endtask

   initial begin
      test_reset();
      test_sweep();
      test_step();
      test_hold();
      test_checker();
      test_hold00();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
